// File: rtl/time_set_rx.sv
// Serial time-of-day setter and clock.
// A UART receiver (8N1, LSB first) feeds a frame parser that accepts
// "T" + HHMMSS in ASCII and loads the running clock. A one-second
// prescaler advances the clock while frames are in progress.
module time_set_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [6:0] H_out,
    output logic [6:0] M_out,
    output logic [6:0] S_out,
    output logic [6:0] set_time,
    output logic       frame_err
);
    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int PRE_W    = $clog2(CLK_HZ);
    localparam logic [7:0] ASCII_T = 8'h54;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} rx_state_t;

    // receiver state
    logic             rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic             byte_valid_reg, byte_valid_next;
    logic             byte_err_reg, byte_err_next;

    // parser and clock state
    logic [2:0]       set_cnt_reg, set_cnt_next;
    logic [4:0][3:0]  digit_reg, digit_next;
    logic             frame_err_reg;
    logic [6:0]       h_reg, m_reg, s_reg;
    logic [PRE_W-1:0] pre_reg;

    logic             is_digit, frame_start, digit_store;
    logic [3:0]       rx_digit;
    logic [6:0]       hh_val, mm_val, ss_val;
    logic             fields_ok, load_now, err_now, tick;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sync1_reg <= 1'b1;
            rx_sync2_reg <= 1'b1;
            rx_prev_reg  <= 1'b1;
        end else begin
            rx_sync1_reg <= rxd;
            rx_sync2_reg <= rx_sync1_reg;
            rx_prev_reg  <= rx_sync2_reg;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            baud_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            byte_valid_reg <= 1'b0;
            byte_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            baud_cnt_reg   <= baud_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            byte_valid_reg <= byte_valid_next;
            byte_err_reg   <= byte_err_next;
        end
    end

    // Receiver next state: mid-bit sampling, start-bit glitch rejection, stop check.
    always_comb begin
        state_next      = state_reg;
        baud_cnt_next   = baud_cnt_reg + CNT_W'(1);
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        byte_valid_next = 1'b0;
        byte_err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                baud_cnt_next = '0;
                if (rx_prev_reg && !rx_sync2_reg) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_cnt_reg == CNT_W'(HALF_DIV - 1)) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = rx_sync2_reg ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_cnt_reg == CNT_W'(BAUD_DIV - 1)) begin
                    baud_cnt_next = '0;
                    shift_next    = {rx_sync2_reg, shift_reg[7:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_cnt_reg == CNT_W'(BAUD_DIV - 1)) begin
                    baud_cnt_next   = '0;
                    state_next      = ST_IDLE;
                    byte_valid_next = rx_sync2_reg;
                    byte_err_next   = !rx_sync2_reg;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign is_digit    = (shift_reg >= 8'h30) && (shift_reg <= 8'h39);
    assign rx_digit    = shift_reg[3:0];
    assign frame_start = byte_valid_reg && (shift_reg == ASCII_T);
    assign digit_store = byte_valid_reg && is_digit;

    // Digit slot gi holds the (gi+1)th digit of the frame; a new 'T' clears all.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_digit
            assign digit_next[gi] = frame_start ? 4'd0 :
                                    (digit_store && set_cnt_reg == 3'(gi + 1)) ? rx_digit :
                                    digit_reg[gi];
        end
    endgenerate

    // The last seconds digit is taken straight from the receiver, not stored.
    assign hh_val    = 7'(digit_reg[0]) * 7'd10 + 7'(digit_reg[1]);
    assign mm_val    = 7'(digit_reg[2]) * 7'd10 + 7'(digit_reg[3]);
    assign ss_val    = 7'(digit_reg[4]) * 7'd10 + 7'(rx_digit);
    assign fields_ok = (hh_val <= 7'd23) && (mm_val <= 7'd59) && (ss_val <= 7'd59);

    // Frame parser decisions for the byte (or framing error) reported this cycle.
    always_comb begin
        set_cnt_next = set_cnt_reg;
        load_now     = 1'b0;
        err_now      = 1'b0;
        if (byte_err_reg) begin
            if (set_cnt_reg != 3'd0) begin
                err_now      = 1'b1;
                set_cnt_next = 3'd0;
            end
        end else if (byte_valid_reg) begin
            if (shift_reg == ASCII_T) begin
                set_cnt_next = 3'd1;
            end else if (set_cnt_reg != 3'd0) begin
                if (!is_digit) begin
                    err_now      = 1'b1;
                    set_cnt_next = 3'd0;
                end else if (set_cnt_reg == 3'd6) begin
                    set_cnt_next = 3'd0;
                    load_now     = fields_ok;
                    err_now      = !fields_ok;
                end else begin
                    set_cnt_next = set_cnt_reg + 3'd1;
                end
            end
        end
    end

    // Parser registers and the one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            set_cnt_reg   <= 3'd0;
            digit_reg     <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            set_cnt_reg   <= set_cnt_next;
            digit_reg     <= digit_next;
            frame_err_reg <= err_now;
        end
    end

    assign tick = (pre_reg == PRE_W'(CLK_HZ - 1));

    // One-second prescaler; a load restarts the second.
    always_ff @(posedge clk) begin
        if (!rst_n || load_now || tick) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + PRE_W'(1);
        end
    end

    // Time-of-day registers; a load takes priority over a coincident tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_reg <= 7'd0;
            m_reg <= 7'd0;
            s_reg <= 7'd0;
        end else if (load_now) begin
            h_reg <= hh_val;
            m_reg <= mm_val;
            s_reg <= ss_val;
        end else if (tick) begin
            if (s_reg == 7'd59) begin
                s_reg <= 7'd0;
                if (m_reg == 7'd59) begin
                    m_reg <= 7'd0;
                    h_reg <= (h_reg == 7'd23) ? 7'd0 : h_reg + 7'd1;
                end else begin
                    m_reg <= m_reg + 7'd1;
                end
            end else begin
                s_reg <= s_reg + 7'd1;
            end
        end
    end

    assign H_out     = h_reg;
    assign M_out     = m_reg;
    assign S_out     = s_reg;
    assign set_time  = {4'b0000, set_cnt_reg};
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_time_set_rx.sv
// Bench for time_set_rx: directed serial frames, a seconds-of-day reference
// model checked every cycle, and literal checkpoints at key moments.
`timescale 1ns/1ps
module tb_time_set_rx;
    localparam int CLK_HZ = 1600;
    localparam int BAUD   = 100;
    localparam int BIT    = CLK_HZ / BAUD;
    // Byte effect becomes visible this many edges after the start bit is driven:
    // 2 sync + 1 edge detect + half bit + 9 bits + 1 parser.
    localparam int LAT    = 3 + BIT / 2 + 9 * BIT + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [6:0] H_out, M_out, S_out, set_time;
    logic       frame_err;

    time_set_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd),
        .H_out(H_out), .M_out(M_out), .S_out(S_out),
        .set_time(set_time), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int ferr_seen = 0;

    typedef struct {
        int         at;
        logic [7:0] b;
        logic       ok;
    } rx_ev_t;
    rx_ev_t ev_q[$];

    // reference model: time as seconds of day, plus the edge of last (re)start
    int   m_sod = 0;
    int   m_base = 0;
    int   m_set = 0;
    int   m_dig[5];
    logic m_ferr = 1'b0;
    logic m_valid = 1'b0;
    logic [28:0] exp_v;

    task automatic finish_sim();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // model step at each rising edge
    always @(posedge clk) begin
        int     hh, mm, ss;
        logic   loaded;
        rx_ev_t e;
        edge_n++;
        m_ferr = 1'b0;
        loaded = 1'b0;
        if (!rst_n) begin
            m_valid = 1'b1;
            m_sod   = 0;
            m_base  = edge_n;
            m_set   = 0;
            ev_q.delete();
        end else if (m_valid) begin
            if (ev_q.size() > 0 && ev_q[0].at == edge_n) begin
                e = ev_q.pop_front();
                if (!e.ok) begin
                    if (m_set != 0) begin m_ferr = 1'b1; m_set = 0; end
                end else if (e.b == 8'h54) begin
                    m_set = 1;
                end else if (m_set != 0) begin
                    if (e.b < 8'h30 || e.b > 8'h39) begin
                        m_ferr = 1'b1;
                        m_set  = 0;
                    end else if (m_set < 6) begin
                        m_dig[m_set-1] = int'(e.b) - 48;
                        m_set++;
                    end else begin
                        hh = m_dig[0] * 10 + m_dig[1];
                        mm = m_dig[2] * 10 + m_dig[3];
                        ss = m_dig[4] * 10 + (int'(e.b) - 48);
                        if (hh <= 23 && mm <= 59 && ss <= 59) begin
                            m_sod  = hh * 3600 + mm * 60 + ss;
                            m_base = edge_n;
                            loaded = 1'b1;
                        end else begin
                            m_ferr = 1'b1;
                        end
                        m_set = 0;
                    end
                end
            end
            if (!loaded && edge_n > m_base && (edge_n - m_base) % CLK_HZ == 0)
                m_sod = (m_sod + 1) % 86400;
        end
    end

    // compare DUT against model every cycle
    always @(negedge clk) begin
        if (m_valid) begin
            exp_v = {7'(m_sod / 3600), 7'((m_sod / 60) % 60), 7'(m_sod % 60), 7'(m_set), m_ferr};
            checks++;
            if ({H_out, M_out, S_out, set_time, frame_err} !== exp_v) begin
                errors++;
                $display("FAIL model edge %0d got %0d:%0d:%0d set=%0d ferr=%b want %0d:%0d:%0d set=%0d ferr=%b",
                         edge_n, H_out, M_out, S_out, set_time, frame_err,
                         exp_v[28:22], exp_v[21:15], exp_v[14:8], exp_v[7:1], exp_v[0]);
                if (errors >= 40) finish_sim();
            end
            if (frame_err === 1'b1) ferr_seen++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired at edge %0d", edge_n);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic check_lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s);
        check_lit({name, "_H"}, int'(H_out), h);
        check_lit({name, "_M"}, int'(M_out), m);
        check_lit({name, "_S"}, int'(S_out), s);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx_ev_t e;
        @(posedge clk); #1;
        e.at = edge_n + LAT;
        e.b  = b;
        e.ok = stop_ok;
        ev_q.push_back(e);
        rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(posedge clk);
            #1 rxd = b[i];
        end
        repeat (BIT) @(posedge clk);
        #1 rxd = stop_ok;
        repeat (BIT) @(posedge clk);
        #1 rxd = 1'b1;
        if (!stop_ok) begin
            repeat (BIT) @(posedge clk);
            #1;
        end
        $display("byte 0x%02h stop=%b started edge %0d", b, stop_ok, e.at - LAT);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        $display("sent \"%s\" done at edge %0d", s, edge_n);
    endtask

    task automatic glitch();
        @(posedge clk); #1 rxd = 1'b0;
        @(posedge clk); #1 rxd = 1'b1;
        repeat (20) @(posedge clk);
        #1 $display("glitch done at edge %0d", edge_n);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        $display("reset pulse at edge %0d", edge_n);
    endtask

    initial begin
        int f0;
        int target;
        string s;

        // reset, then free-running seconds
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_time("reset", 0, 0, 0);
        check_lit("reset_set", int'(set_time), 0);
        check_lit("reset_ferr", int'(frame_err), 0);
        repeat (3 * CLK_HZ) @(posedge clk);
        #1 check_time("run3", 0, 0, 3);

        // minute and hour carry
        send_str("T005959");
        check_time("load005959", 0, 59, 59);
        repeat (CLK_HZ) @(posedge clk);
        #1 check_time("carry_hour", 1, 0, 0);

        // set_time steps, then day wrap
        s = "T235958";
        for (int i = 0; i < 7; i++) begin
            send_byte(s[i], 1'b1);
            if (i < 6) check_lit("set_step", int'(set_time), i + 1);
        end
        check_time("load235958", 23, 59, 58);
        check_lit("load_set0", int'(set_time), 0);
        repeat (2 * CLK_HZ) @(posedge clk);
        #1 check_time("day_wrap", 0, 0, 0);

        // out-of-range hour
        f0 = ferr_seen;
        send_str("T245000");
        check_lit("bad_hour_pulses", ferr_seen - f0, 1);
        check_lit("bad_hour_set", int'(set_time), 0);

        // restart on second 'T'
        f0 = ferr_seen;
        send_str("T12T123456");
        check_time("restart", 12, 34, 56);
        check_lit("restart_pulses", ferr_seen - f0, 0);

        // framing error mid-frame, framing error idle, glitch mid-frame
        send_str("T12");
        f0 = ferr_seen;
        send_byte("3", 1'b0);
        check_lit("stop_err_pulses", ferr_seen - f0, 1);
        check_lit("stop_err_set", int'(set_time), 0);
        f0 = ferr_seen;
        send_byte("7", 1'b0);
        check_lit("idle_stop_err", ferr_seen - f0, 0);
        send_str("T0");
        glitch();
        check_lit("glitch_set", int'(set_time), 2);
        send_str("70809");
        check_time("after_glitch", 7, 8, 9);

        // reset mid-frame
        send_str("T1234");
        f0 = ferr_seen;
        pulse_reset();
        check_time("mid_reset", 0, 0, 0);
        check_lit("mid_reset_set", int'(set_time), 0);
        check_lit("mid_reset_pulses", ferr_seen - f0, 0);
        send_str("T000005");
        check_time("load000005", 0, 0, 5);

        // non-digit mid-frame, stray digit while idle
        f0 = ferr_seen;
        send_str("T1A");
        check_lit("nondigit_pulses", ferr_seen - f0, 1);
        f0 = ferr_seen;
        send_str("5");
        check_lit("stray_pulses", ferr_seen - f0, 0);
        check_lit("stray_set", int'(set_time), 0);

        // load landing on a tick edge: load wins
        target = m_base - (6 * (10 * BIT + 1) + LAT);
        while (target <= edge_n + 1) target += CLK_HZ;
        while (edge_n < target - 1) begin
            @(posedge clk);
            #1;
        end
        send_str("T111111");
        check_time("load_vs_tick", 11, 11, 11);
        repeat (CLK_HZ) @(posedge clk);
        #1 check_time("after_collision", 11, 11, 12);

        finish_sim();
    end
endmodule
